// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: four-way round-robin arbiter with a locked grant and a one-cycle release gap.
// Define ARB_TIMEOUT_EN to revoke any grant held for TIMEOUT_CYCLES cycles.
module rr_grant_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       arb_clk,
  input  logic       arb_rst_n,
  input  logic [3:0] arb_req,
  input  logic       arb_done,
  output logic [1:0] arb_gnt,
  output logic       arb_gnt_vld,
  output logic [3:0] arb_gnt_onehot,
  output logic       arb_timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state;
  logic [1:0] ptr, c1, c2, c3, win;
  logic rel, expire;
  always_comb begin
    c1 = ptr + 2'd1;
    c2 = ptr + 2'd2;
    c3 = ptr + 2'd3;
    win = arb_req[c1] ? c1 : arb_req[c2] ? c2 : arb_req[c3] ? c3 : ptr;
    rel = arb_done | ~arb_req[arb_gnt];
  end
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign expire = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expire = 1'b0;
  assign arb_timeout = 1'b0;
`endif
  always_ff @(posedge arb_clk or negedge arb_rst_n)
    if (!arb_rst_n) begin
      state <= IDLE;
      ptr <= 2'd3;
      arb_gnt <= 2'b00;
      arb_gnt_vld <= 1'b0;
      arb_gnt_onehot <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
      cnt <= '0;
      arb_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      cnt <= state == GRANT ? cnt + 1'b1 : '0;
      arb_timeout <= 1'b0;
`endif
      case (state)
        IDLE: if (|arb_req) begin
          state <= GRANT;
          arb_gnt <= win;
          arb_gnt_vld <= 1'b1;
          arb_gnt_onehot <= 4'b0001 << win;
        end
        GRANT: if (rel | expire) begin
          state <= RELEASE;
          ptr <= arb_gnt;
          arb_gnt_vld <= 1'b0;
          arb_gnt_onehot <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
          arb_timeout <= ~rel;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb_rr_grant_sequencer: directed scoreboard bench; stimulus queues expected grant indices, a negedge monitor checks them.
module tb_rr_grant_sequencer;
  logic arb_clk = 1'b0;
  logic arb_rst_n = 1'b0;
  logic arb_done = 1'b0;
  logic [3:0] arb_req = 4'b0000;
  logic [1:0] arb_gnt;
  logic arb_gnt_vld, arb_timeout;
  logic [3:0] arb_gnt_onehot;
  int tests = 0, fails = 0;
  int lows, hi;
  logic [1:0] exp_q[$];
  logic prev_vld = 1'b0;
  logic [1:0] rot[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] fair[4] = '{2'd3, 2'd0, 2'd3, 2'd0};
  logic [3:0] lock_pat[4] = '{4'b1011, 4'b0111, 4'b1110, 4'b0010};

  rr_grant_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .arb_clk(arb_clk), .arb_rst_n(arb_rst_n), .arb_req(arb_req), .arb_done(arb_done),
    .arb_gnt(arb_gnt), .arb_gnt_vld(arb_gnt_vld), .arb_gnt_onehot(arb_gnt_onehot),
    .arb_timeout(arb_timeout)
  );

  always #5 arb_clk = ~arb_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge arb_clk);
    #1;
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!arb_gnt_vld && n < 20) begin
      tick();
      n++;
    end
    if (!arb_gnt_vld) begin
      tests++;
      fails++;
      $display("FAIL wait_vld: no grant after %0d cycles", n);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"}, arb_gnt, 2'b00);
    check({tag, "_vld"}, arb_gnt_vld, 1'b0);
    check({tag, "_onehot"}, arb_gnt_onehot, 4'b0000);
    check({tag, "_timeout"}, arb_timeout, 1'b0);
  endtask

  task automatic do_reset;
    tick();
    arb_rst_n = 1'b0;
    #1;
    check_reset("rst");
    tick();
    tick();
    arb_rst_n = 1'b1;
  endtask

  // Grant order and one-hot consistency are checked whenever the DUT presents a grant.
  always @(negedge arb_clk) begin
    if (arb_gnt_vld && !prev_vld) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got %0d expected none", arb_gnt);
      end else check("grant_idx", arb_gnt, exp_q.pop_front());
    end
    check("onehot", arb_gnt_onehot, arb_gnt_vld ? (4'b0001 << arb_gnt) : 4'b0000);
    prev_vld = arb_gnt_vld;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check_reset("por");
    arb_rst_n = 1'b1;
    arb_req = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    check("req_to_grant_vld", arb_gnt_vld, 1'b1);
    check("req_to_grant_gnt", arb_gnt, 2'd2);
    tick();
    tick();
    arb_done = 1'b1;
    tick();
    arb_done = 1'b0;
    check("done_to_release", arb_gnt_vld, 1'b0);
    check("release_keeps_gnt", arb_gnt, 2'd2);
    tick();
    check("idle_gap", arb_gnt_vld, 1'b0);
    exp_q.push_back(2'd2);
    tick();
    check("single_regrant", arb_gnt_vld, 1'b1);
    arb_req = 4'b0000;
    tick();
    check("drop_release", arb_gnt_vld, 1'b0);

    do_reset();
    arb_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(rot[i]);
      wait_vld(lows);
      if (i > 0) check("rot_gap", lows, 2);
      arb_done = 1'b1;
      tick();
      arb_done = 1'b0;
      check("min_hold_release", arb_gnt_vld, 1'b0);
    end
    arb_req = 4'b0000;
    tick();
    tick();

    do_reset();
    arb_req = 4'b0001;
    exp_q.push_back(2'd0);
    wait_vld(lows);
    arb_done = 1'b1;
    arb_req = 4'b1001;
    tick();
    arb_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(fair[i]);
      wait_vld(lows);
      check("fair_gap", lows, 2);
      arb_done = 1'b1;
      tick();
      arb_done = 1'b0;
    end
    arb_req = 4'b0000;
    tick();
    tick();

    do_reset();
    arb_req = 4'b0010;
    exp_q.push_back(2'd1);
    wait_vld(lows);
    for (int i = 0; i < 4; i++) begin
      arb_req = lock_pat[i];
      tick();
      check("lock_gnt", arb_gnt, 2'd1);
      check("lock_vld", arb_gnt_vld, 1'b1);
    end
    arb_req = 4'b1101;
    tick();
    check("owner_drop_release", arb_gnt_vld, 1'b0);
    check("owner_drop_keep_gnt", arb_gnt, 2'd1);
    exp_q.push_back(2'd2);
    wait_vld(lows);
    check("after_drop_gap", lows, 2);
    arb_done = 1'b1;
    arb_req = 4'b1001;
    tick();
    arb_done = 1'b0;
    check("done_drop_release", arb_gnt_vld, 1'b0);
    exp_q.push_back(2'd3);
    wait_vld(lows);
    check("done_drop_gap", lows, 2);
    arb_req = 4'b0000;
    tick();
    tick();
    arb_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_in_idle", arb_gnt_vld, 1'b0);
    end
    arb_done = 1'b0;

    do_reset();
    arb_req = 4'b0011;
    exp_q.push_back(2'd0);
    wait_vld(lows);
    hi = 0;
    while (arb_gnt_vld && hi < 12) begin
      check("no_early_timeout", arb_timeout, 1'b0);
      tick();
      hi++;
    end
`ifdef ARB_TIMEOUT_EN
    check("timeout_hold", hi, 4);
    check("timeout_pulse", arb_timeout, 1'b1);
    tick();
    check("timeout_one_cycle", arb_timeout, 1'b0);
    exp_q.push_back(2'd1);
    wait_vld(lows);
    tick();
    tick();
    tick();
    check("cycle4_vld", arb_gnt_vld, 1'b1);
    arb_done = 1'b1;
    tick();
    arb_done = 1'b0;
    check("done_beats_timeout_vld", arb_gnt_vld, 1'b0);
    check("done_beats_timeout", arb_timeout, 1'b0);
    exp_q.push_back(2'd0);
    wait_vld(lows);
    arb_req = 4'b0000;
    tick();
`else
    check("hold_indefinite", hi, 12);
    check("hold_vld", arb_gnt_vld, 1'b1);
    arb_done = 1'b1;
    arb_req = 4'b0000;
    tick();
    arb_done = 1'b0;
    check("hold_release", arb_gnt_vld, 1'b0);
    check("timeout_tied", arb_timeout, 1'b0);
`endif
    tick();

    do_reset();
    arb_req = 4'b0001;
    exp_q.push_back(2'd0);
    wait_vld(lows);
    arb_done = 1'b1;
    arb_req = 4'b1000;
    tick();
    arb_done = 1'b0;
    exp_q.push_back(2'd3);
    wait_vld(lows);
    tick();
    check("pre_reset_gnt", arb_gnt, 2'd3);
    #2;
    arb_rst_n = 1'b0;
    #1;
    check_reset("async");
    arb_req = 4'b1111;
    tick();
    tick();
    arb_rst_n = 1'b1;
    exp_q.push_back(2'd0);
    wait_vld(lows);
    check("post_reset_first", arb_gnt, 2'd0);
    arb_req = 4'b0000;
    tick();
    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
